l23_tx_fcs_padder: RTL
======================

# l23_tx_fcs_padder

Transmit-side finishing stage placed directly downstream of L23_buffer: it consumes the byte stream carrying the encapsulated frames (prepended header plus payload) and delivers wire-ready Ethernet frames to the MAC/PHY interface. Each frame is zero-padded to a minimum length and gets a 4-byte CRC-32 FCS appended. A configurable inter-frame gap is enforced after every frame. A wrapping frame counter is exposed for management.

## Interface
- MIN_LEN, 60: minimum frame length in bytes before FCS; shorter frames are zero-padded. 0 disables padding.
- IFG, 12: idle cycles after the last FCS byte handshake before the next frame is accepted.
- L23_clk  in  1  single clock, all logic on rising edge.
- L23_rst  in  1  reset, asynchronous and active-low.
- L23i_tdata  in  8  input byte (from L23_buffer L23o_tdata).
- L23i_tlast  in  1  last payload byte of frame.
- L23i_tvalid  in  1  input byte valid.
- L23i_tready  out  1  block accepts input byte.
- L23o_tdata  out  8  output byte.
- L23o_tlast  out  1  asserted on final FCS byte only.
- L23o_tvalid  out  1  output byte valid.
- L23o_tready  in  1  sink accepts output byte.
- L23_frames_sent  out  16  count of completed frames (final FCS byte handshaken), wraps at 0xFFFF→0x0000.

## Operation
- Single output register (tdata/tlast/tvalid); load allowed when !L23o_tvalid or L23o_tready ("slot free").
- FSM states: DATA, PAD, FCS, GAP. Reset state DATA.
- DATA: L23i_tready = slot free. Each input handshake loads byte into output register, updates CRC, increments 16-bit length counter (saturates at 0xFFFF). On handshake with L23i_tlast: if length+1 < MIN_LEN → PAD, else → FCS. Input tlast is never forwarded.
- PAD: L23i_tready=0. Each free slot loads 0x00, updates CRC, increments length; after loading the byte that makes length = MIN_LEN → FCS.
- FCS: L23i_tready=0. FCS = ~crc; loads bytes FCS[7:0], [15:8], [23:16], [31:24] in that order, one per free slot; 4th byte carries L23o_tlast=1. After 4th byte is loaded, CRC reinitialised, length cleared, → GAP (or DATA if IFG=0).
- GAP: L23i_tready=0; counter starts when final FCS byte is handshaken at output; after IFG cycles → DATA.
- CRC: IEEE 802.3 reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte, covers data and pad bytes only.
- L23_frames_sent increments on output handshake with L23o_tlast=1.

## Timing
- Reset values: L23o_tvalid=0, L23o_tdata=0x00, L23o_tlast=0, L23i_tready=0 while reset asserted, L23_frames_sent=0, CRC=0xFFFFFFFF, length=0, IFG counter=0.
- Latency: byte accepted at edge N is on L23o from edge N (valid after N, until handshaken); full throughput 1 byte/cycle with L23o_tready held high.
- While L23o_tvalid=1 and L23o_tready=0, L23o_tdata/tlast held stable; L23i_tready=0.
- Frame of L ≥ MIN_LEN bytes occupies L+4 output beats; L < MIN_LEN occupies MIN_LEN+4.
- Exactly MIN_LEN-1 input bytes then tlast on byte MIN_LEN: no pad bytes.
- Single-byte frame: legal; padded.
- Reset asserted mid-frame: all state cleared immediately; partial frame discarded, no tlast emitted.
- L23i_tvalid dropping mid-frame: FSM waits in DATA; no padding inserted.

## Test plan
- Standard check, MIN_LEN=0, IFG=0: input "123456789" (0x31..0x39, tlast on 0x39), tready=1 → output 0x31..0x39, 0x26, 0x39, 0xF4, 0xCB, tlast only on 0xCB; L23_frames_sent=1.
- Padding, defaults: 14-byte frame → 46 bytes 0x00 after data, 64 beats total, tlast on beat 64; bench recomputes CRC over all 64 output bytes, raw register residue = 0xDEBB20E3.
- Boundary: 59-byte frame → one pad byte (64 beats); 60-byte frame → zero pad bytes (64 beats); 61-byte frame → 65 beats.
- Gap, IFG=12: two back-to-back frames → L23i_tready low exactly 12 cycles after final FCS handshake, first byte of frame 2 accepted on cycle 13; with random L23o_tready, gap measured from the actual handshake.
- Random backpressure: random L23i_tvalid/L23o_tready (~50%) over 200 cycles, frames from L23_buffer stimulus → output byte stream equals reference model (pad+FCS), tdata stable while stalled, no byte lost/duplicated.
- Reset mid-frame: assert L23_rst low during PAD → L23o_tvalid=0 asynchronously; next frame after release produces correct FCS and L23_frames_sent restarts from 0.

Source files
------------

// File: rtl/l23_tx_fcs_padder.sv
// rtl/l23_tx_fcs_padder.sv - pads frames to MIN_LEN, appends CRC-32 FCS and enforces the inter-frame gap
module l23_tx_fcs_padder #(
  parameter int MIN_LEN = 60,
  parameter int IFG     = 12
) (
  input  logic        L23_clk,
  input  logic        L23_rst,
  input  logic [7:0]  L23i_tdata,
  input  logic        L23i_tlast,
  input  logic        L23i_tvalid,
  output logic        L23i_tready,
  output logic [7:0]  L23o_tdata,
  output logic        L23o_tlast,
  output logic        L23o_tvalid,
  input  logic        L23o_tready,
  output logic [15:0] L23_frames_sent
);

  // Gap counter must hold IFG; keep at least one bit so IFG=0 still elaborates.
  localparam int              GW        = (IFG > 0) ? $clog2(IFG + 1) : 1;
  localparam logic [GW-1:0]   IFG_W     = GW'(IFG);
  localparam logic [GW-1:0]   GAP_ONE   = GW'(1);
  localparam logic [16:0]     MIN_LEN_W = 17'(MIN_LEN);
  localparam logic [31:0]     CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0]     CRC_POLY  = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tlast_q, tlast_d;
  logic            tvalid_q, tvalid_d;
  logic [31:0]     crc_q, crc_d;
  logic [15:0]     len_q, len_d;
  logic [1:0]      fcs_idx_q, fcs_idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     frames_q, frames_d;

  logic            slot_free;
  logic            in_ready;
  logic            in_hs;
  logic            out_last_hs;
  logic            load_en;
  logic [7:0]      load_byte;
  logic            load_last;
  logic            crc_en;
  logic [16:0]     len_inc;
  logic [15:0]     len_sat;
  logic [31:0]     fcs;

  // Reflected CRC-32, one data bit per step, least significant bit first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) begin
        r = {1'b0, r[31:1]} ^ CRC_POLY;
      end else begin
        r = {1'b0, r[31:1]};
      end
    end
    return r;
  endfunction

  // The single output register may take a new byte when empty or being drained.
  assign slot_free   = !tvalid_q || L23o_tready;
  assign in_ready    = (state_q == ST_DATA) && slot_free && L23_rst;
  assign in_hs       = in_ready && L23i_tvalid;
  assign out_last_hs = tvalid_q && tlast_q && L23o_tready;
  assign len_inc     = {1'b0, len_q} + 17'd1;
  assign len_sat     = (len_q == 16'hFFFF) ? len_q : len_inc[15:0];
  assign fcs         = ~crc_q;

  // State register.
  always_ff @(posedge L23_clk or negedge L23_rst) begin
    if (!L23_rst) begin
      state_q <= ST_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DATA until input tlast, PAD up to MIN_LEN, 4 FCS beats, then the gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DATA: begin
        if (in_hs && L23i_tlast) begin
          state_d = (len_inc < MIN_LEN_W) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        if (slot_free && (len_inc >= MIN_LEN_W)) begin
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        if (slot_free && (fcs_idx_q == 2'd3)) begin
          state_d = (IFG == 0) ? ST_DATA : ST_GAP;
        end
      end
      ST_GAP: begin
        // gap_q == 0 means the final FCS byte has not been handshaken yet.
        if (gap_q == GAP_ONE) begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  // FSM outputs: what (if anything) goes into the output register this cycle.
  always_comb begin
    load_en   = 1'b0;
    load_byte = 8'h00;
    load_last = 1'b0;
    crc_en    = 1'b0;
    unique case (state_q)
      ST_DATA: begin
        load_en   = in_hs;
        load_byte = L23i_tdata;
        crc_en    = in_hs;
      end
      ST_PAD: begin
        load_en   = slot_free;
        load_byte = 8'h00;
        crc_en    = slot_free;
      end
      ST_FCS: begin
        load_en   = slot_free;
        load_last = (fcs_idx_q == 2'd3);
        unique case (fcs_idx_q)
          2'd0:    load_byte = fcs[7:0];
          2'd1:    load_byte = fcs[15:8];
          2'd2:    load_byte = fcs[23:16];
          default: load_byte = fcs[31:24];
        endcase
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Datapath next-state: output register, CRC/length accumulation, FCS index, gap and frame counters.
  always_comb begin
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    crc_d     = crc_q;
    len_d     = len_q;
    fcs_idx_d = fcs_idx_q;
    gap_d     = gap_q;
    frames_d  = frames_q;

    if (slot_free) begin
      tvalid_d = load_en;
      if (load_en) begin
        tdata_d = load_byte;
        tlast_d = load_last;
      end else begin
        tlast_d = 1'b0;
      end
    end

    if (crc_en) begin
      crc_d = crc32_byte(crc_q, load_byte);
      len_d = len_sat;
    end

    if ((state_q == ST_FCS) && slot_free) begin
      if (fcs_idx_q == 2'd3) begin
        crc_d     = CRC_INIT;
        len_d     = 16'd0;
        fcs_idx_d = 2'd0;
      end else begin
        fcs_idx_d = fcs_idx_q + 2'd1;
      end
    end

    // Gap counting starts only once the tlast beat has actually left.
    if (state_q == ST_GAP) begin
      if (gap_q == '0) begin
        if (out_last_hs) begin
          gap_d = IFG_W;
        end
      end else begin
        gap_d = gap_q - GAP_ONE;
      end
    end

    if (out_last_hs) begin
      frames_d = frames_q + 16'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge L23_clk or negedge L23_rst) begin
    if (!L23_rst) begin
      tdata_q   <= 8'h00;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      crc_q     <= CRC_INIT;
      len_q     <= 16'd0;
      fcs_idx_q <= 2'd0;
      gap_q     <= '0;
      frames_q  <= 16'd0;
    end else begin
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      fcs_idx_q <= fcs_idx_d;
      gap_q     <= gap_d;
      frames_q  <= frames_d;
    end
  end

  assign L23i_tready     = in_ready;
  assign L23o_tdata      = tdata_q;
  assign L23o_tlast      = tlast_q;
  assign L23o_tvalid     = tvalid_q;
  assign L23_frames_sent = frames_q;

endmodule
